// File: rtl/mmc_cmd_seq_pkg.sv
// Shared definitions for the MMC command sequencer:
// FSM states, frame geometry and the CRC7 step.
package mmc_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_TURN = 3'd2,
    ST_WAIT = 3'd3,
    ST_RX   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int FRAME_LEN = 48;
  localparam int CRC_LEN   = 40;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       d
  );
    logic fb;
    fb = d ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_cmd_seq_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one bit per enable.
// crc_nxt exposes the value after the current bit is absorbed.
module crc7_d1 (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [6:0] crc,
  output logic [6:0] crc_nxt
);
  import mmc_cmd_seq_pkg::*;

  assign crc_nxt = crc7_step(crc, d);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/mmc_cmd_seq.sv
// MMC command sequencer: frames a command, paces every bit through
// the external clock generator and optionally captures a response.
module mmc_cmd_seq #(
  parameter int RESP_TIMEOUT = 64,
  parameter int TURN_CYCLES  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_en,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        crc_err,
  output logic [37:0] resp,
  output logic        clk_tick,
  input  logic        clk_rdy,
  input  logic        clk_done,
  output logic        mmc_cmd_o,
  output logic        mmc_cmd_oe,
  input  logic        mmc_cmd_i
);
  import mmc_cmd_seq_pkg::*;

  localparam int BW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] CRC_BITS  = BW'(CRC_LEN);
  localparam logic [BW-1:0] CRC_TAIL  = BW'(CRC_LEN - 1);
  localparam logic [BW-1:0] TURN_LAST = BW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);

  state_t        state;
  logic          pend;
  logic          abrt;
  logic          resp_en_q;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] wcnt;
  logic [46:0]   tx_sr;
  logic [44:0]   rx_sr;

  logic          active;
  logic          stop;
  logic          fire;
  logic          adv;
  logic          crc_clr;
  logic          crc_en;
  logic          crc_d;
  logic [6:0]    crc;
  logic [6:0]    crc_nxt;

  assign active = state inside {ST_TX, ST_TURN, ST_WAIT, ST_RX};
  assign stop   = abort | abrt;
  assign fire   = clk_done & pend;
  assign adv    = fire & ~stop & active;

  // Combinational so a tick can never be raised while clk_rdy is low.
  assign clk_tick = ~wb_rst_i & active & ~pend & ~stop & clk_rdy;

  assign crc_clr = (state == ST_IDLE && start) ||
                   (state == ST_WAIT && adv && !mmc_cmd_i);
  assign crc_en  = adv && (bcnt < CRC_BITS) &&
                   (state == ST_TX || state == ST_RX);
  assign crc_d   = (state == ST_TX) ? mmc_cmd_o : mmc_cmd_i;

  crc7_d1 u_crc (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (crc_clr),
    .en       (crc_en),
    .d        (crc_d),
    .crc      (crc),
    .crc_nxt  (crc_nxt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      crc_err    <= 1'b0;
      resp       <= '0;
      mmc_cmd_o  <= 1'b1;
      mmc_cmd_oe <= 1'b0;
      bcnt       <= '0;
      wcnt       <= '0;
      pend       <= 1'b0;
      abrt       <= 1'b0;
      resp_en_q  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      done <= 1'b0;

      if (clk_tick) begin
        pend <= 1'b1;
      end else if (fire) begin
        pend <= 1'b0;
      end

      if (active && stop) begin
        mmc_cmd_oe <= 1'b0;
        mmc_cmd_o  <= 1'b1;
        // Let an outstanding tick land before finishing.
        if (!pend || clk_done) begin
          abrt  <= 1'b0;
          state <= ST_FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          abrt <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              busy       <= 1'b1;
              timeout    <= 1'b0;
              crc_err    <= 1'b0;
              resp_en_q  <= resp_en;
              tx_sr      <= {1'b1, cmd_index, cmd_arg, 8'h00};
              mmc_cmd_o  <= 1'b0;
              mmc_cmd_oe <= 1'b1;
              bcnt       <= '0;
              state      <= ST_TX;
            end
          end

          ST_TX: begin
            if (adv) begin
              if (bcnt == LAST_BIT) begin
                mmc_cmd_oe <= 1'b0;
                mmc_cmd_o  <= 1'b1;
                bcnt       <= '0;
                wcnt       <= '0;
                if (!resp_en_q) begin
                  state <= ST_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else if (TURN_CYCLES == 0) begin
                  state <= ST_WAIT;
                end else begin
                  state <= ST_TURN;
                end
              end else if (bcnt == CRC_TAIL) begin
                mmc_cmd_o <= crc_nxt[6];
                tx_sr     <= {crc_nxt[5:0], 1'b1, 40'h0};
                bcnt      <= bcnt + 1'b1;
              end else begin
                mmc_cmd_o <= tx_sr[46];
                tx_sr     <= {tx_sr[45:0], 1'b0};
                bcnt      <= bcnt + 1'b1;
              end
            end
          end

          ST_TURN: begin
            if (adv) begin
              if (bcnt == TURN_LAST) begin
                bcnt  <= '0;
                wcnt  <= '0;
                state <= ST_WAIT;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end

          ST_WAIT: begin
            if (adv) begin
              if (!mmc_cmd_i) begin
                bcnt  <= BW'(1);
                state <= ST_RX;
              end else if (wcnt == TO_LAST) begin
                wcnt    <= wcnt + 1'b1;
                timeout <= 1'b1;
                state   <= ST_FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                wcnt <= wcnt + 1'b1;
              end
            end
          end

          ST_RX: begin
            if (adv) begin
              rx_sr <= {rx_sr[43:0], mmc_cmd_i};
              // rx_sr holds response bit b at index b-1 here.
              if (bcnt == LAST_BIT) begin
                resp    <= rx_sr[44:7];
                crc_err <= (rx_sr[6:0] != crc);
                state   <= ST_FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end

          ST_FIN: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmc_cmd_seq.sv
// Directed bench for mmc_cmd_seq with a clock-generator model,
// a response driver and a frame model built from CRC division.
module tb_mmc_cmd_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        crc_err;
  logic [37:0] resp;
  logic        clk_tick;
  logic        clk_rdy;
  bit          clk_done;
  logic        mmc_cmd_o;
  logic        mmc_cmd_oe;
  logic        mmc_cmd_i;

  mmc_cmd_seq dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .abort      (abort),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_en    (resp_en),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .crc_err    (crc_err),
    .resp       (resp),
    .clk_tick   (clk_tick),
    .clk_rdy    (clk_rdy),
    .clk_done   (clk_done),
    .mmc_cmd_o  (mmc_cmd_o),
    .mmc_cmd_oe (mmc_cmd_oe),
    .mmc_cmd_i  (mmc_cmd_i)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of m(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'h00};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx,
                                           input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_div(m), 1'b1};
  endfunction

  // clock generator model
  bit       gbusy;
  int       gcnt;
  bit       rdy_hold = 1'b0;
  assign clk_rdy = ~gbusy & ~rdy_hold;

  always @(posedge clk) begin
    if (rst) begin
      gbusy    <= 1'b0;
      gcnt     <= 0;
      clk_done <= 1'b0;
    end else begin
      clk_done <= 1'b0;
      if (clk_tick) begin
        gbusy <= 1'b1;
        gcnt  <= LAT;
      end else if (gbusy) begin
        if (gcnt == 1) begin
          gbusy    <= 1'b0;
          clk_done <= 1'b1;
        end else begin
          gcnt <= gcnt - 1;
        end
      end
    end
  end

  int ndone = 0;
  always @(posedge clk) if (clk_done) ndone <= ndone + 1;

  // model / response state, written only by the main process
  int          n0     = 0;
  int          tx_len = 48;
  bit          in_cmd = 1'b0;
  logic [47:0] exp_frame = '0;
  bit          rsp_on = 1'b0;
  int          rs     = 0;
  logic [47:0] rsp    = '0;

  int kk;
  always_comb begin
    kk        = ndone - n0;
    mmc_cmd_i = 1'b1;
    if (rsp_on && kk >= rs && kk < rs + 48)
      mmc_cmd_i = rsp[47 - (kk - rs)];
  end

  int ntick   = 0;
  int ndpulse = 0;
  always @(negedge clk) begin
    if (clk_tick === 1'b1) ntick <= ntick + 1;
    if (done === 1'b1) ndpulse <= ndpulse + 1;
  end

  logic [47:0] cap = '0;
  always @(negedge clk) begin
    int k;
    if (clk_rdy === 1'b0) chk("tick_while_not_rdy", clk_tick, 1'b0);
    if (done === 1'b1) chk("busy_at_done", busy, 1'b0);
    if (clk_done && in_cmd) begin
      k = ndone - n0;
      if (k < tx_len) begin
        chk("tx_oe", mmc_cmd_oe, 1'b1);
        chk("tx_bit", mmc_cmd_o, exp_frame[47 - k]);
        cap <= {cap[46:0], mmc_cmd_o};
      end else begin
        chk("rel_oe", mmc_cmd_oe, 1'b0);
        chk("rel_o", mmc_cmd_o, 1'b1);
      end
    end
  end

  task automatic issue(input logic [5:0] idx,
                       input logic [31:0] arg,
                       input logic ren);
    @(negedge clk);
    cmd_index = idx;
    cmd_arg   = arg;
    resp_en   = ren;
    exp_frame = frame_of(idx, arg);
    n0        = ndone;
    in_cmd    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(output int k);
    bit ok;
    ok = 1'b0;
    k  = -1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        k  = ndone - n0;
      end
    end
    chk("done_seen", ok, 1'b1);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    in_cmd = 1'b0;
  endtask

  task automatic wait_k(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (ndone - n0 >= target) ok = 1'b1;
    end
    chk("reach_bit", ok, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int dp0;
    int nt0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_en   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_crc_err", crc_err, 1'b0);
    chk("rst_resp", resp, 38'h0);
    chk("rst_tick", clk_tick, 1'b0);
    chk("rst_cmd_o", mmc_cmd_o, 1'b1);
    chk("rst_cmd_oe", mmc_cmd_oe, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CMD0, no response
    chk("model_cmd0", frame_of(6'd0, 32'h0), 48'h400000000095);
    issue(6'd0, 32'h0, 1'b0);
    wait_done(k);
    chk("cmd0_frame", cap, 48'h400000000095);
    chk("cmd0_ticks", k, 48);
    chk("cmd0_timeout", timeout, 1'b0);
    chk("cmd0_busy", busy, 1'b0);

    // CMD8 with clk_rdy stall and an ignored start
    chk("model_cmd8", frame_of(6'd8, 32'h1AA), 48'h48000001AA87);
    issue(6'd8, 32'h000001AA, 1'b0);
    wait_k(10);
    rdy_hold = 1'b1;
    nt0 = ntick;
    cmd_index = 6'h3F;
    cmd_arg   = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_no_tick", ntick - nt0, 0);
    chk("ignored_start_busy", busy, 1'b1);
    rdy_hold = 1'b0;
    wait_done(k);
    chk("cmd8_frame", cap, 48'h48000001AA87);
    chk("cmd8_ticks", k, 48);

    // response expected, line idle -> timeout
    issue(6'd8, 32'h000001AA, 1'b1);
    wait_done(k);
    chk("to_ticks", k, 48 + 2 + 64);
    chk("to_flag", timeout, 1'b1);
    chk("to_crc_err", crc_err, 1'b0);

    // valid R7 response after 3 idle samples
    chk("model_r7_crc", crc7_div(40'h08000001AA), 7'h09);
    rsp    = 48'h08000001AA13;
    rs     = 53;
    rsp_on = 1'b1;
    issue(6'd8, 32'h000001AA, 1'b1);
    wait_done(k);
    chk("r7_resp", resp, 38'h08000001AA);
    chk("r7_crc_err", crc_err, 1'b0);
    chk("r7_timeout", timeout, 1'b0);
    chk("r7_ticks", k, 101);

    // same response with payload bit 20 flipped
    rsp = 48'h08000001AA13 ^ 48'h000000100000;
    issue(6'd8, 32'h000001AA, 1'b1);
    wait_done(k);
    chk("bad_crc_err", crc_err, 1'b1);
    chk("bad_resp", resp, 38'h08000001AA ^ 38'h1000);
    rsp_on = 1'b0;

    // abort at TX bit 20
    tx_len = 20;
    dp0 = ndpulse;
    issue(6'd0, 32'h0, 1'b0);
    chk("start_clears_crc_err", crc_err, 1'b0);
    wait_k(20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (30) @(negedge clk);
    nt0 = ntick;
    repeat (20) @(negedge clk);
    in_cmd = 1'b0;
    chk("abort_done_pulses", ndpulse - dp0, 1);
    chk("abort_oe", mmc_cmd_oe, 1'b0);
    chk("abort_cmd_o", mmc_cmd_o, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_no_tick", ntick - nt0, 0);
    chk("abort_timeout", timeout, 1'b0);
    tx_len = 48;

    // reset at RX bit 10 of a good R7
    rsp    = 48'h08000001AA13;
    rs     = 53;
    rsp_on = 1'b1;
    issue(6'd8, 32'h000001AA, 1'b1);
    wait_k(rs + 10);
    dp0 = ndpulse;
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rsp_on = 1'b0;
    in_cmd = 1'b0;
    nt0 = ntick;
    repeat (40) @(negedge clk);
    chk("rst_mid_done", ndpulse - dp0, 0);
    chk("rst_mid_tick", ntick - nt0, 0);
    chk("rst_mid_oe", mmc_cmd_oe, 1'b0);
    chk("rst_mid_o", mmc_cmd_o, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_resp", resp, 38'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
